dual_core_mem_arbiter: RTL and testbench

//  Shares one single-port data memory between core 0 and core 1 of Processor_Multiport.

---
 rtl/mp_arb_pkg.sv | 29 ++
 rtl/mp_rr_pick.sv | 25 ++
 rtl/dual_core_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dual_core_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_arb_pkg.sv
// Shared definitions for the dual-core memory arbiter: FSM state encoding,
// port select constants, statistics counter width and a saturating increment.
package mp_arb_pkg;

    // Arbiter sequencing states. Exposed on the arbiter's dbg_state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Port select values used for grant, latched select and round-robin pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Width of the optional statistics counters.
    localparam int STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        r = v;
        if (v != {STAT_W{1'b1}}) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mp_rr_pick.sv
// Two-way round-robin chooser. Purely combinational; the pointer register
// lives in the parent. rr_ptr names the port that wins a tie, so the parent
// moves it to the other port each time an access completes.
module mp_rr_pick
    import mp_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant_sel
);

    // A single requester always wins; a tie goes to the favoured port.
    always_comb begin
        grant_valid = req0 | req1;
        grant_sel   = PORT0;
        if (req0 && req1) begin
            grant_sel = rr_ptr;
        end else if (req1) begin
            grant_sel = PORT1;
        end
    end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Shares one single-port data RAM between two cores. Accesses are serialised
// IDLE -> ISSUE -> WAIT -> IDLE with round-robin tie breaking; the winning core
// gets a one-cycle ack (and read data) MEM_LATENCY cycles after mem_en.
//
// Handshake: a core raises reqN with weN/addrN/wdataN stable and holds them
// until ackN. ackN is a single-cycle pulse; rdataN is valid in that cycle and
// held until the next ackN. A req still high in the cycle after its ack is a
// new request. Requests are only sampled while the FSM is in IDLE.
//
// Optional build macro: ARB_STATS_EN adds live grant/conflict counters; when
// undefined the counter ports exist but are tied to zero.
// MEM_LATENCY legal range is 1..4.
module dual_core_mem_arbiter
    import mp_arb_pkg::*;
#(
    parameter int reg_width   = 12,
    parameter int addr_width  = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [reg_width-1:0]  wdata0,
    input  logic [reg_width-1:0]  wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [reg_width-1:0]  rdata0,
    output logic [reg_width-1:0]  rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [reg_width-1:0]  mem_wdata,
    input  logic [reg_width-1:0]  mem_rdata,
    output logic                  busy,
    output logic [STAT_W-1:0]     grant_cnt0,
    output logic [STAT_W-1:0]     grant_cnt1,
    output logic [STAT_W-1:0]     conflict_cnt,
    output arb_state_e            dbg_state
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY);

    arb_state_e            state;
    arb_state_e            state_nxt;
    logic [2:0]            lat_cnt;
    logic                  rr_ptr;
    logic                  sel_q;
    logic                  we_q;
    logic [addr_width-1:0] addr_q;
    logic [reg_width-1:0]  wdata_q;
    logic [reg_width-1:0]  rdata0_q;
    logic [reg_width-1:0]  rdata1_q;
    logic                  grant_valid;
    logic                  grant_sel;
    logic                  idle_grant;
    logic                  lat_done;

    mp_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    assign idle_grant = (state == ST_IDLE) && grant_valid;
    assign lat_done   = (state == ST_WAIT) && (lat_cnt == LAT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (lat_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's request; these registers drive the RAM pins directly
    // and therefore hold their value between accesses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q   <= PORT0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (idle_grant) begin
            sel_q <= grant_sel;
            if (grant_sel == PORT1) begin
                we_q    <= we1;
                addr_q  <= addr1;
                wdata_q <= wdata1;
            end else begin
                we_q    <= we0;
                addr_q  <= addr0;
                wdata_q <= wdata0;
            end
        end
    end

    // Count cycles since mem_en; starts at 1 in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_ISSUE: lat_cnt <= 3'd1;
                ST_WAIT:  lat_cnt <= lat_done ? 3'd0 : lat_cnt + 3'd1;
                default:  lat_cnt <= lat_cnt;
            endcase
        end
    end

    // After a completion the other port is favoured on the next tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= PORT0;
        end else if (lat_done) begin
            rr_ptr <= (sel_q == PORT0) ? PORT1 : PORT0;
        end
    end

    // Strobes and read-data return. ack/mem_en are masked by reset so that an
    // access caught by reset never completes.
    always_comb begin
        mem_en = reset && (state == ST_ISSUE);
        ack0   = reset && lat_done && (sel_q == PORT0);
        ack1   = reset && lat_done && (sel_q == PORT1);
        rdata0 = (ack0 && !we_q) ? mem_rdata : rdata0_q;
        rdata1 = (ack1 && !we_q) ? mem_rdata : rdata1_q;
    end

    // Hold the last returned read data per port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0;
            rdata1_q <= rdata1;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt0_q;
    logic [STAT_W-1:0] grant_cnt1_q;
    logic [STAT_W-1:0] conflict_cnt_q;

    // Saturating grant and conflict counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (ack0) grant_cnt0_q <= sat_inc(grant_cnt0_q);
            if (ack1) grant_cnt1_q <= sat_inc(grant_cnt1_q);
            if ((state == ST_IDLE) && req0 && req1) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`else
    assign grant_cnt0   = '0;
    assign grant_cnt1   = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Bench for dual_core_mem_arbiter: two instances (MEM_LATENCY 1 and 3), each
// with its own RAM model, random core traffic and a transaction-level model.
module tb_dual_core_mem_arbiter;
    import mp_arb_pkg::*;

    localparam int RW      = 12;
    localparam int AW      = 8;
    localparam int N_RAND  = 600;
    localparam int MAX_CYC = 6000;
`ifdef ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [RW-1:0] wdata;
    } txn_t;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]    reset_s, req0_s, req1_s, we0_s, we1_s;
    logic [AW-1:0] addr0_s [2];
    logic [AW-1:0] addr1_s [2];
    logic [RW-1:0] wdata0_s [2];
    logic [RW-1:0] wdata1_s [2];
    wire  [1:0]    ack0_o, ack1_o, mem_en_o, mem_we_o, busy_o;
    wire  [RW-1:0] rdata0_o [2];
    wire  [RW-1:0] rdata1_o [2];
    wire  [RW-1:0] mem_wdata_o [2];
    wire  [RW-1:0] mem_rdata_s [2];
    wire  [AW-1:0] mem_addr_o [2];
    wire  [15:0]   gc0_o [2];
    wire  [15:0]   gc1_o [2];
    wire  [15:0]   cc_o [2];
    wire  [1:0]    dbg_o [2];

    function automatic logic [RW-1:0] init_word(input int a);
        logic [RW-1:0] w;
        w = RW'(a * 37 + 'h5A3);
        if (a == 'h2A) w = 12'hABC;
        return w;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [RW-1:0] mem_arr [256];
        logic [RW-1:0] pipe [4];

        initial begin
            for (int a = 0; a < 256; a++) mem_arr[a] = init_word(a);
            for (int i = 0; i < 4; i++) pipe[i] = '0;
        end

        // RAM model: write on mem_en, read data appears LAT cycles later;
        // junk is returned whenever no read is in flight.
        always @(posedge clk) begin
            if (mem_en_o[g] && mem_we_o[g]) mem_arr[mem_addr_o[g]] <= mem_wdata_o[g];
            if (mem_en_o[g] && !mem_we_o[g]) pipe[0] <= mem_arr[mem_addr_o[g]];
            else pipe[0] <= RW'($urandom);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_s[g] = pipe[LAT-1];

        dual_core_mem_arbiter #(
            .reg_width   (RW),
            .addr_width  (AW),
            .MEM_LATENCY (LAT)
        ) u_dut (
            .clk          (clk),
            .reset        (reset_s[g]),
            .req0         (req0_s[g]),
            .req1         (req1_s[g]),
            .we0          (we0_s[g]),
            .we1          (we1_s[g]),
            .addr0        (addr0_s[g]),
            .addr1        (addr1_s[g]),
            .wdata0       (wdata0_s[g]),
            .wdata1       (wdata1_s[g]),
            .ack0         (ack0_o[g]),
            .ack1         (ack1_o[g]),
            .rdata0       (rdata0_o[g]),
            .rdata1       (rdata1_o[g]),
            .mem_en       (mem_en_o[g]),
            .mem_we       (mem_we_o[g]),
            .mem_addr     (mem_addr_o[g]),
            .mem_wdata    (mem_wdata_o[g]),
            .mem_rdata    (mem_rdata_s[g]),
            .busy         (busy_o[g]),
            .grant_cnt0   (gc0_o[g]),
            .grant_cnt1   (gc1_o[g]),
            .conflict_cnt (cc_o[g]),
            .dbg_state    (dbg_o[g])
        );
    end

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int            next_sample [2];
    int            mem_en_cyc [2];
    int            ack_cyc [2];
    logic          fav [2];
    txn_t          pend [2];
    logic          pend_sel [2];
    logic [RW-1:0] pend_rdata [2];
    logic          exp_we [2];
    logic [AW-1:0] exp_addr [2];
    logic [RW-1:0] exp_wdata [2];
    logic [RW-1:0] exp_rd0 [2];
    logic [RW-1:0] exp_rd1 [2];
    logic [RW-1:0] shadow [2][256];
    int            exp_gc0 [2];
    int            exp_gc1 [2];
    int            exp_cc [2];

    // ---------------- driver state ----------------
    txn_t txq [4][$];
    logic act [2][2];
    int   phase [2];
    int   abort_at [2];
    int   rst_until [2];
    logic [1:0] done_f;
    int   ord_q [2][$];
    int   exp_q [2][$];

    function automatic txn_t mk_txn(input logic we, input logic [AW-1:0] a, input logic [RW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       t.addr = '0;
            1:       t.addr = '1;
            default: t.addr = AW'($urandom);
        endcase
        t.wdata = RW'($urandom);
        return t;
    endfunction

    task automatic clear_model(input int g, input int c);
        next_sample[g] = c + 1;
        mem_en_cyc[g]  = -1;
        ack_cyc[g]     = -1;
        fav[g]         = 1'b0;
        exp_we[g]      = 1'b0;
        exp_addr[g]    = '0;
        exp_wdata[g]   = '0;
        exp_rd0[g]     = '0;
        exp_rd1[g]     = '0;
        exp_gc0[g]     = 0;
        exp_gc1[g]     = 0;
        exp_cc[g]      = 0;
    endtask

    // One cycle for instance g: check outputs, advance drivers, advance model.
    task automatic step(input int g, input int c);
        string         p;
        logic          ack_now, busy_e, e_ack0, e_ack1, rst_d, w, keep;
        logic [RW-1:0] e_rd0, e_rd1;
        int            L;
        L = lat_of(g);
        p = (g == 0) ? "lat1 " : "lat3 ";

        // memory access performed this cycle
        if (c == mem_en_cyc[g]) begin
            exp_we[g]    = pend[g].we;
            exp_addr[g]  = pend[g].addr;
            exp_wdata[g] = pend[g].wdata;
            if (pend[g].we) shadow[g][pend[g].addr] = pend[g].wdata;
            else pend_rdata[g] = shadow[g][pend[g].addr];
        end
        ack_now = (c == ack_cyc[g]);
        busy_e  = (mem_en_cyc[g] >= 0) && (c >= mem_en_cyc[g]) && (c <= ack_cyc[g]);
        e_ack0  = ack_now && (pend_sel[g] == 1'b0);
        e_ack1  = ack_now && (pend_sel[g] == 1'b1);
        e_rd0   = (e_ack0 && !pend[g].we) ? pend_rdata[g] : exp_rd0[g];
        e_rd1   = (e_ack1 && !pend[g].we) ? pend_rdata[g] : exp_rd1[g];

        check({p, "busy"},      32'(busy_o[g]),      32'(busy_e));
        check({p, "idle_st"},   32'(dbg_o[g] == 2'(ST_IDLE)), 32'(!busy_e));
        check({p, "mem_en"},    32'(mem_en_o[g]),    32'(c == mem_en_cyc[g]));
        check({p, "mem_we"},    32'(mem_we_o[g]),    32'(exp_we[g]));
        check({p, "mem_addr"},  32'(mem_addr_o[g]),  32'(exp_addr[g]));
        check({p, "mem_wdata"}, 32'(mem_wdata_o[g]), 32'(exp_wdata[g]));
        check({p, "ack0"},      32'(ack0_o[g]),      32'(e_ack0));
        check({p, "ack1"},      32'(ack1_o[g]),      32'(e_ack1));
        check({p, "rdata0"},    32'(rdata0_o[g]),    32'(e_rd0));
        check({p, "rdata1"},    32'(rdata1_o[g]),    32'(e_rd1));
        check({p, "grant_cnt0"},   32'(gc0_o[g]), STATS_ON ? 32'(16'(exp_gc0[g])) : 32'd0);
        check({p, "grant_cnt1"},   32'(gc1_o[g]), STATS_ON ? 32'(16'(exp_gc1[g])) : 32'd0);
        check({p, "conflict_cnt"}, 32'(cc_o[g]),  STATS_ON ? 32'(16'(exp_cc[g]))  : 32'd0);

        if (phase[g] == 3) begin
            if (ack0_o[g]) ord_q[g].push_back(0);
            if (ack1_o[g]) ord_q[g].push_back(1);
        end

        // completion: core retires the transaction and may issue the next at once
        if (ack_now) begin
            exp_rd0[g] = e_rd0;
            exp_rd1[g] = e_rd1;
            if (pend_sel[g]) exp_gc1[g]++; else exp_gc0[g]++;
            void'(txq[g*2 + int'(pend_sel[g])].pop_front());
            keep = (txq[g*2 + int'(pend_sel[g])].size() != 0) &&
                   ((phase[g] == 3) || ($urandom_range(0, 1) == 1));
            act[g][pend_sel[g]] = keep;
        end

        // scenario sequencing
        case (phase[g])
            0: if (c >= 3) phase[g] = 1;
            1: begin
                if (c < 3 + N_RAND) begin
                    for (int q = 0; q < 2; q++)
                        while (txq[g*2+q].size() < 2) txq[g*2+q].push_back(rand_txn());
                end else begin
                    phase[g] = 2;
                end
            end
            2: begin
                if (txq[g*2].size() == 0 && txq[g*2+1].size() == 0 &&
                    !act[g][0] && !act[g][1] && c >= next_sample[g]) begin
                    txq[g*2].push_back(mk_txn(1'b0, 8'h3C, '0));
                    act[g][0]   = 1'b1;
                    abort_at[g] = -1;
                    phase[g]    = 4;
                end
            end
            4: begin
                if (c == abort_at[g]) begin
                    rst_until[g] = c + 2;
                    txq[g*2].push_back(rand_txn());
                    txq[g*2+1].push_back(rand_txn());
                    txq[g*2+1].push_back(rand_txn());
                    act[g][1] = 1'b1;
                    phase[g]  = 5;
                end
            end
            5: if (c >= rst_until[g]) phase[g] = 3;
            3: begin
                if (txq[g*2].size() == 0 && txq[g*2+1].size() == 0 &&
                    !act[g][0] && !act[g][1] && c >= next_sample[g]) begin
                    done_f[g] = 1'b1;
                    phase[g]  = 6;
                end
            end
            default: ;
        endcase
        rst_d = !((phase[g] == 0) || (phase[g] == 5));

        // raise idle cores that have work queued
        for (int q = 0; q < 2; q++) begin
            if (!act[g][q] && txq[g*2+q].size() != 0 && $urandom_range(0, 2) == 0)
                act[g][q] = 1'b1;
        end

        // drive pins for the coming edge
        reset_s[g] = rst_d;
        req0_s[g]  = act[g][0];
        req1_s[g]  = act[g][1];
        if (txq[g*2].size() != 0) begin
            we0_s[g] = txq[g*2][0].we; addr0_s[g] = txq[g*2][0].addr; wdata0_s[g] = txq[g*2][0].wdata;
        end
        if (txq[g*2+1].size() != 0) begin
            we1_s[g] = txq[g*2+1][0].we; addr1_s[g] = txq[g*2+1][0].addr; wdata1_s[g] = txq[g*2+1][0].wdata;
        end

        // arbitration decision at this edge
        if (!rst_d) begin
            clear_model(g, c);
        end else if (c >= next_sample[g]) begin
            if (act[g][0] || act[g][1]) begin
                if (act[g][0] && act[g][1]) begin
                    w = fav[g];
                    exp_cc[g]++;
                end else begin
                    w = act[g][1];
                end
                pend_sel[g]    = w;
                pend[g]        = txq[g*2 + int'(w)][0];
                fav[g]         = !w;
                mem_en_cyc[g]  = c + 1;
                ack_cyc[g]     = c + 1 + L;
                next_sample[g] = c + 2 + L;
                if (phase[g] == 4 && w == 1'b0) abort_at[g] = mem_en_cyc[g] + ((L > 1) ? 1 : 0);
                if (phase[g] == 3) exp_q[g].push_back(int'(w));
            end else begin
                next_sample[g] = c + 1;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        done_f = 2'b00;
        for (int g = 0; g < 2; g++) begin
            reset_s[g] = 1'b0; req0_s[g] = 1'b1; req1_s[g] = 1'b0;
            we0_s[g] = 1'b0; we1_s[g] = 1'b0;
            addr0_s[g] = 8'h2A; addr1_s[g] = '0; wdata0_s[g] = '0; wdata1_s[g] = '0;
            for (int a = 0; a < 256; a++) shadow[g][a] = init_word(a);
            clear_model(g, 0);
            next_sample[g] = 0;
            phase[g] = 0; abort_at[g] = -1; rst_until[g] = 0;
            pend[g] = '0; pend_sel[g] = 1'b0; pend_rdata[g] = '0;
            txq[g*2].push_back(mk_txn(1'b0, 8'h2A, '0));
            txq[g*2].push_back(mk_txn(1'b0, 8'hFF, '0));
            txq[g*2+1].push_back(mk_txn(1'b1, 8'h05, 12'h123));
            act[g][0] = 1'b1;
            act[g][1] = 1'b0;
        end

        @(posedge clk);
        cyc = 1;
        while (done_f != 2'b11 && cyc < MAX_CYC) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) step(g, cyc);
            cyc++;
        end
        check("run_complete", 32'(done_f), 32'd3);

        for (int g = 0; g < 2; g++) begin
            check("order_len", 32'(ord_q[g].size()), 32'd4);
            check("model_order_len", 32'(exp_q[g].size()), 32'd4);
            while (ord_q[g].size() != 0 && exp_q[g].size() != 0) begin
                check("grant_order", 32'(ord_q[g].pop_front()), 32'(exp_q[g].pop_front()));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
